// File: rtl/conv_sched_pkg.sv
// Shared types for the layer scheduler: the descriptor handed to instgen and the FSM state.
package conv_sched_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] feature_baseaddr;
        logic [ADDR_W-1:0] kernel_baseaddr;
        logic [ADDR_W-1:0] output_baseaddr;
        logic [DATA_W-1:0] feature_width;
        logic [DATA_W-1:0] feature_height;
        logic [DATA_W-1:0] feature_chin;
        logic [DATA_W-1:0] feature_chout;
        logic [DATA_W-1:0] kernel_sizeh;
        logic [DATA_W-1:0] kernel_sizew;
        logic [DATA_W-1:0] stride;
        logic [DATA_W-1:0] output_width;
        logic [DATA_W-1:0] output_height;
        logic              has_bias;
        logic              has_relu;
        logic              use_prev_out;
    } conv_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RETIRE
    } sched_state_e;

    // Chained layers read their input from the previous layer's output buffer.
    function automatic conv_desc_t resolve_chain(input conv_desc_t d, input logic [ADDR_W-1:0] prev);
        conv_desc_t r;
        r = d;
        if (d.use_prev_out) r.feature_baseaddr = prev;
        return r;
    endfunction

endpackage

// File: rtl/conv_desc_fifo.sv
// Small circular-buffer FIFO holding pending layer descriptors; flush empties it in one edge.
module conv_desc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);
    // Acceptance depends only on the registered count, so a full queue never takes a push.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/conv_layer_sched.sv
// Layer scheduler: queues descriptors, issues them to instgen one at a time, tracks completion.
//   state     | meaning
//   ST_IDLE   | nothing in flight; pops the queue head when enabled
//   ST_ISSUE  | csrcmd_valid high, waiting for instgen_ready
//   ST_WAIT   | layer running in instgen; watchdog counting
//   ST_RETIRE | one cycle: irq, retired count, chaining address update
module conv_layer_sched
    import conv_sched_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int TIMEOUT_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sched_en,
    input  logic                    abort,
    input  logic                    desc_valid,
    output logic                    desc_ready,
    input  conv_desc_t              desc_in,
    output logic                    csrcmd_valid,
    input  logic                    instgen_ready,
    output conv_desc_t              desc_out,
    input  logic                    conv_complete,
    output logic                    busy,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [15:0]             layers_done,
    output logic                    irq_layer,
    output logic                    err_timeout,
    output logic                    err_spurious,
    input  logic                    err_clr
);
    localparam logic [TIMEOUT_W-1:0] WD_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] WD_LAST = WD_MAX - TIMEOUT_W'(1);

    sched_state_e        state;
    conv_desc_t          cur_desc;
    conv_desc_t          fifo_head;
    logic [ADDR_W-1:0]   prev_out_addr;
    logic [TIMEOUT_W-1:0] watchdog;
    logic                aborting;
    logic                fifo_full;
    logic                fifo_empty;
    logic                start_issue;

    conv_desc_fifo #(.DEPTH(DEPTH), .WIDTH($bits(conv_desc_t))) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (desc_valid),
        .pop   (start_issue),
        .flush (abort),
        .din   (desc_in),
        .dout  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign desc_ready  = !fifo_full;
    assign busy        = (state != ST_IDLE) || !fifo_empty;
    assign desc_out    = cur_desc;
    assign start_issue = (state == ST_IDLE) && sched_en && !fifo_empty && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cur_desc      <= '0;
            prev_out_addr <= '0;
            watchdog      <= '0;
            aborting      <= 1'b0;
            csrcmd_valid  <= 1'b0;
            layers_done   <= '0;
            irq_layer     <= 1'b0;
            err_timeout   <= 1'b0;
            err_spurious  <= 1'b0;
        end else begin
            irq_layer <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_issue) begin
                        cur_desc     <= resolve_chain(fifo_head, prev_out_addr);
                        csrcmd_valid <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A handshake in the abort cycle means instgen already owns the layer.
                    if (instgen_ready) begin
                        csrcmd_valid <= 1'b0;
                        aborting     <= abort;
                        state        <= ST_WAIT;
                    end else if (abort) begin
                        csrcmd_valid <= 1'b0;
                        state        <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (conv_complete) begin
                        watchdog      <= '0;
                        aborting      <= 1'b0;
                        prev_out_addr <= cur_desc.output_baseaddr;
                        if (aborting || abort) begin
                            state <= ST_IDLE;
                        end else begin
                            state       <= ST_RETIRE;
                            irq_layer   <= 1'b1;
                            layers_done <= layers_done + 16'd1;
                        end
                    end else begin
                        if (abort) aborting <= 1'b1;
                        if (watchdog != WD_MAX) watchdog <= watchdog + TIMEOUT_W'(1);
                    end
                end
                ST_RETIRE: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase

            if (err_clr)
                err_timeout <= 1'b0;
            else if (state == ST_WAIT && !conv_complete && watchdog == WD_LAST)
                err_timeout <= 1'b1;

            if (err_clr)
                err_spurious <= 1'b0;
            else if (conv_complete && state != ST_WAIT)
                err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed plus randomized bench for conv_layer_sched against a queue-based layer model.
module tb_conv_layer_sched;
    import conv_sched_pkg::*;

    localparam int DEPTH = 4;
    localparam int TW    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sched_en = 1'b0;
    logic       abort = 1'b0;
    logic       desc_valid = 1'b0;
    logic       desc_ready;
    conv_desc_t desc_in = '0;
    logic       csrcmd_valid;
    logic       instgen_ready = 1'b0;
    conv_desc_t desc_out;
    logic       conv_complete = 1'b0;
    logic       busy;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [15:0] layers_done;
    logic       irq_layer;
    logic       err_timeout;
    logic       err_spurious;
    logic       err_clr = 1'b0;

    always #5 clk = ~clk;

    conv_layer_sched #(.DEPTH(DEPTH), .TIMEOUT_W(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .sched_en      (sched_en),
        .abort         (abort),
        .desc_valid    (desc_valid),
        .desc_ready    (desc_ready),
        .desc_in       (desc_in),
        .csrcmd_valid  (csrcmd_valid),
        .instgen_ready (instgen_ready),
        .desc_out      (desc_out),
        .conv_complete (conv_complete),
        .busy          (busy),
        .fifo_count    (fifo_count),
        .layers_done   (layers_done),
        .irq_layer     (irq_layer),
        .err_timeout   (err_timeout),
        .err_spurious  (err_spurious),
        .err_clr       (err_clr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending descriptors, last output buffer, retired count.
    conv_desc_t        model_q[$];
    logic [ADDR_W-1:0] m_prev = '0;
    int unsigned       m_done = 0;
    conv_desc_t        cur_exp = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic conv_desc_t rand_desc(input bit chain);
        conv_desc_t d;
        d.feature_baseaddr = $urandom;
        d.kernel_baseaddr  = $urandom;
        d.output_baseaddr  = $urandom;
        d.feature_width    = DATA_W'($urandom);
        d.feature_height   = DATA_W'($urandom);
        d.feature_chin     = DATA_W'($urandom);
        d.feature_chout    = DATA_W'($urandom);
        d.kernel_sizeh     = DATA_W'($urandom);
        d.kernel_sizew     = DATA_W'($urandom);
        d.stride           = DATA_W'($urandom);
        d.output_width     = DATA_W'($urandom);
        d.output_height    = DATA_W'($urandom);
        d.has_bias         = 1'($urandom);
        d.has_relu         = 1'($urandom);
        d.use_prev_out     = chain;
        return d;
    endfunction

    // The next layer instgen should see: queue head, with chained input address substituted.
    function automatic conv_desc_t expect_head();
        conv_desc_t d;
        d = model_q.pop_front();
        if (d.use_prev_out) d.feature_baseaddr = m_prev;
        return d;
    endfunction

    task automatic push_desc(input conv_desc_t d);
        desc_valid = 1'b1;
        desc_in    = d;
        step();
        desc_valid = 1'b0;
        model_q.push_back(d);
    endtask

    task automatic wait_valid();
        int t = 0;
        while (!csrcmd_valid && t < 8) begin
            step();
            t++;
        end
        chk("issue_seen", 256'(csrcmd_valid), 256'(1));
    endtask

    task automatic issue_layer(input int ready_delay);
        wait_valid();
        cur_exp = expect_head();
        chk("desc_out", 256'(desc_out), 256'(cur_exp));
        for (int i = 0; i < ready_delay; i++) begin
            step();
            chk("hold_valid", 256'(csrcmd_valid), 256'(1));
            chk("hold_desc", 256'(desc_out), 256'(cur_exp));
        end
        instgen_ready = 1'b1;
        step();
        instgen_ready = 1'b0;
        chk("valid_drop", 256'(csrcmd_valid), 256'(0));
    endtask

    task automatic complete_layer(input int delay, input bit aborted);
        repeat (delay) step();
        conv_complete = 1'b1;
        step();
        conv_complete = 1'b0;
        m_prev = cur_exp.output_baseaddr;
        if (!aborted) m_done++;
        chk("irq", 256'(irq_layer), 256'(!aborted));
        chk("layers_done", 256'(layers_done), 256'(m_done[15:0]));
        step();
        chk("irq_end", 256'(irq_layer), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed stall expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        conv_desc_t d;
        conv_desc_t held;
        bit exp_ready;

        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 256'(desc_ready), 256'(1));
        chk("rst_valid", 256'(csrcmd_valid), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_count", 256'(fifo_count), 256'(0));
        chk("rst_done", 256'(layers_done), 256'(0));
        chk("rst_irq", 256'(irq_layer), 256'(0));
        chk("rst_errs", 256'({err_timeout, err_spurious}), 256'(0));
        chk("rst_desc", 256'(desc_out), 256'(0));

        // Single layer with issue latency
        sched_en = 1'b1;
        d = rand_desc(1'b0);
        d.output_baseaddr = 32'h2000;
        push_desc(d);
        chk("lat1", 256'(csrcmd_valid), 256'(0));
        step();
        chk("lat2", 256'(csrcmd_valid), 256'(1));
        issue_layer(0);
        complete_layer(10, 1'b0);
        chk("single_busy", 256'(busy), 256'(0));

        // Chaining
        d = rand_desc(1'b0);
        d.output_baseaddr = 32'h3000;
        push_desc(d);
        d = rand_desc(1'b1);
        d.feature_baseaddr = 32'hDEAD;
        push_desc(d);
        issue_layer(0);
        complete_layer(3, 1'b0);
        issue_layer(2);
        chk("chain_feat", 256'(desc_out.feature_baseaddr), 256'(32'h3000));
        complete_layer(4, 1'b0);

        // Backpressure: fill with the scheduler disabled
        sched_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_ready = (model_q.size() < DEPTH);
            chk("fill_ready", 256'(desc_ready), 256'(exp_ready));
            desc_valid = 1'b1;
            desc_in = rand_desc(1'($urandom));
            held = desc_in;
            step();
            desc_valid = 1'b0;
            if (exp_ready) model_q.push_back(held);
        end
        chk("full_count", 256'(fifo_count), 256'(4));
        chk("full_ready", 256'(desc_ready), 256'(0));
        sched_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue_layer(int'($urandom_range(0, 3)));
            complete_layer(int'($urandom_range(0, 6)), 1'b0);
        end
        chk("drain_count", 256'(fifo_count), 256'(0));

        // Held handshake
        push_desc(rand_desc(1'b1));
        issue_layer(7);
        complete_layer(2, 1'b0);

        // Abort in ISSUE
        push_desc(rand_desc(1'b0));
        wait_valid();
        void'(expect_head());
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_issue_valid", 256'(csrcmd_valid), 256'(0));
        step();
        chk("abort_issue_busy", 256'(busy), 256'(0));
        chk("abort_issue_done", 256'(layers_done), 256'(m_done[15:0]));

        // Abort in WAIT with two descriptors queued
        sched_en = 1'b0;
        for (int i = 0; i < 3; i++) push_desc(rand_desc(1'($urandom)));
        sched_en = 1'b1;
        issue_layer(1);
        chk("wait_count", 256'(fifo_count), 256'(2));
        abort = 1'b1;
        step();
        abort = 1'b0;
        model_q.delete();
        chk("abort_flush", 256'(fifo_count), 256'(0));
        chk("abort_busy_wait", 256'(busy), 256'(1));
        complete_layer(3, 1'b1);
        chk("abort_idle", 256'(busy), 256'(0));
        push_desc(rand_desc(1'b1));
        issue_layer(0);
        complete_layer(1, 1'b0);

        // Errors
        conv_complete = 1'b1;
        step();
        conv_complete = 1'b0;
        chk("spurious_set", 256'(err_spurious), 256'(1));
        chk("spurious_no_to", 256'(err_timeout), 256'(0));
        chk("spurious_done", 256'(layers_done), 256'(m_done[15:0]));
        push_desc(rand_desc(1'b0));
        issue_layer(0);
        repeat (14) step();
        chk("to_early", 256'(err_timeout), 256'(0));
        step();
        chk("to_fire", 256'(err_timeout), 256'(1));
        repeat (5) step();
        chk("to_sticky", 256'(err_timeout), 256'(1));
        chk("to_still_wait", 256'(busy), 256'(1));
        complete_layer(0, 1'b0);
        err_clr = 1'b1;
        conv_complete = 1'b1;
        step();
        err_clr = 1'b0;
        conv_complete = 1'b0;
        chk("clr_spurious", 256'(err_spurious), 256'(0));
        chk("clr_timeout", 256'(err_timeout), 256'(0));

        // Randomized traffic
        for (int n = 0; n < 12; n++) begin
            if (model_q.size() < 2) begin
                int k = int'($urandom_range(1, 2));
                for (int j = 0; j < k; j++) push_desc(rand_desc(1'($urandom)));
            end
            issue_layer(int'($urandom_range(0, 3)));
            complete_layer(int'($urandom_range(0, 10)), 1'b0);
        end
        while (model_q.size() > 0) begin
            issue_layer(int'($urandom_range(0, 3)));
            complete_layer(int'($urandom_range(0, 10)), 1'b0);
        end
        chk("end_busy", 256'(busy), 256'(0));
        chk("end_errs", 256'({err_timeout, err_spurious}), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
